// File: rtl/dsp_access_buffer_if.sv
// 36-bit fifo36 stream: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy.
// The master drives data/src_rdy and the slave drives dst_rdy.
interface dsp_access_buffer_if;
    logic [35:0] data;
    logic        src_rdy;
    logic        dst_rdy;

    modport master (output data, output src_rdy, input dst_rdy);
    modport slave  (input data, input src_rdy, output dst_rdy);
endinterface

// File: rtl/dsp_access_buffer.sv
// Single-packet buffer around an in-place DSP engine: fill from a stream,
// lend the RAM to the engine, then drain the (possibly rewritten) packet.
//
// state       | meaning
// FILL        | accept words into RAM; words without SOF at address 0 are dropped
// DROP        | packet overflowed the RAM; discard words up to its EOF
// ACCESS      | packet resident; engine owns the RAM port
// DRAIN_PRIME | read address 0 so the first output word is ready
// DRAIN       | stream RAM contents out until the last word transfers
module dsp_access_buffer #(
    parameter int BUF_SIZE = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    dsp_access_buffer_if.slave     in_bus,
    dsp_access_buffer_if.master    out_bus,
    output logic                   access_ok,
    output logic [BUF_SIZE-1:0]    access_len,
    input  logic [BUF_SIZE-1:0]    access_adr,
    input  logic                   access_stb,
    input  logic                   access_we,
    input  logic [35:0]            access_dat_i,
    output logic [35:0]            access_dat_o,
    input  logic                   access_done,
    input  logic                   access_skip_read
);
    localparam logic [BUF_SIZE-1:0] ADR_MAX = '1;
    localparam logic [BUF_SIZE-1:0] ONE     = BUF_SIZE'(1);

    typedef enum logic [2:0] {FILL, DROP, ACCESS, DRAIN_PRIME, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [BUF_SIZE-1:0] wr_adr, wr_adr_nxt;
    logic [BUF_SIZE-1:0] rd_adr, rd_adr_nxt;
    logic [BUF_SIZE-1:0] len_nxt;

    logic [35:0]         mem [2**BUF_SIZE];
    logic [35:0]         ram_q;
    logic                ram_en, ram_we;
    logic [BUF_SIZE-1:0] ram_adr;
    logic [35:0]         ram_din;

    logic                in_sof, in_eof, last_word;

    assign in_sof = in_bus.data[32];
    assign in_eof = in_bus.data[33];

    // A full-size packet stores access_len as 0; the subtraction wraps to the top address.
    assign last_word = ram_q[33] || (rd_adr == (access_len - ONE));

    assign access_dat_o = ram_q;
    assign out_bus.data = (state == DRAIN) ? {ram_q[35:34], last_word, ram_q[32:0]} : '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= FILL;
            wr_adr     <= '0;
            rd_adr     <= '0;
            access_len <= '0;
        end else begin
            state      <= state_nxt;
            wr_adr     <= wr_adr_nxt;
            rd_adr     <= rd_adr_nxt;
            access_len <= len_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_adr] <= ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ram_q <= '0;
        end else if (ram_en && !ram_we) begin
            ram_q <= mem[ram_adr];
        end
    end

    always_comb begin
        state_nxt       = state;
        wr_adr_nxt      = wr_adr;
        rd_adr_nxt      = rd_adr;
        len_nxt         = access_len;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_adr         = wr_adr;
        ram_din         = in_bus.data;
        in_bus.dst_rdy  = 1'b0;
        out_bus.src_rdy = 1'b0;
        access_ok       = 1'b0;

        case (state)
            FILL: begin
                in_bus.dst_rdy = 1'b1;
                if (in_bus.src_rdy && (wr_adr != '0 || in_sof)) begin
                    ram_en     = 1'b1;
                    ram_we     = 1'b1;
                    wr_adr_nxt = wr_adr + ONE;
                    if (in_eof) begin
                        len_nxt    = wr_adr + ONE;
                        wr_adr_nxt = '0;
                        state_nxt  = ACCESS;
                    end else if (wr_adr == ADR_MAX) begin
                        state_nxt  = DROP;
                    end
                end
            end
            DROP: begin
                in_bus.dst_rdy = 1'b1;
                if (in_bus.src_rdy && in_eof) begin
                    wr_adr_nxt = '0;
                    state_nxt  = FILL;
                end
            end
            ACCESS: begin
                access_ok = 1'b1;
                ram_en    = access_stb;
                ram_we    = access_stb && access_we;
                ram_adr   = access_adr;
                ram_din   = access_dat_i;
                if (access_done) begin
                    state_nxt = access_skip_read ? FILL : DRAIN_PRIME;
                end
            end
            DRAIN_PRIME: begin
                ram_en     = 1'b1;
                ram_adr    = '0;
                rd_adr_nxt = '0;
                state_nxt  = DRAIN;
            end
            DRAIN: begin
                out_bus.src_rdy = 1'b1;
                if (out_bus.dst_rdy) begin
                    if (last_word) begin
                        rd_adr_nxt = '0;
                        wr_adr_nxt = '0;
                        state_nxt  = FILL;
                    end else begin
                        // Fetch the following word now so the stream has no bubbles.
                        rd_adr_nxt = rd_adr + ONE;
                        ram_en     = 1'b1;
                        ram_adr    = rd_adr + ONE;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end
endmodule
